// File: rtl/kfmmc_pkg.sv
// Shared types, constants and the CRC7 byte update for the KFMMC command sequencer.
package kfmmc_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_PRE,
    SEQ_CMD,
    SEQ_RESP,
    SEQ_POST,
    SEQ_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    BYTE_ISSUE,
    BYTE_WAIT_HI,
    BYTE_WAIT_LO
  } byte_state_t;

  localparam logic [7:0] FILL_BYTE      = 8'hFF;
  localparam logic [1:0] CMD_START_BITS = 2'b01;
  localparam logic [6:0] CRC7_POLY      = 7'h09;

  // MSB-first CRC7 (x^7 + x^3 + 1) over one byte.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return crc;
  endfunction

endpackage

// File: rtl/kfmmc_crc7.sv
// Running CRC7 over the command frame bytes; cleared when a command is accepted.
module kfmmc_crc7
  import kfmmc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       update_i,
  input  logic [7:0] data_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 7'h00;
    end else if (clear_i) begin
      crc_q <= 7'h00;
    end else if (update_i) begin
      crc_q <= crc7_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/kfmmc_command_sequencer.sv
// One SPI-mode MMC/SD command transaction: chip select, 6-byte frame, NCR-bounded
// R1 polling and trailing clocks, driven through a byte-wide SPI engine.
module kfmmc_command_sequencer
  import kfmmc_pkg::*;
#(
  parameter int NCR_MAX        = 8,
  parameter int PRE_FILL_BYTES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        command_start,
  input  logic [5:0]  command_index,
  input  logic [31:0] command_argument,
  output logic        command_busy,
  output logic        command_done,
  output logic [7:0]  response_r1,
  output logic        response_timeout,
  output logic        mmc_cs_n,
  output logic [7:0]  spi_send_data,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic [7:0]  spi_recv_data,
  output seq_state_t  debug_state,
  output byte_state_t debug_byte_state
);

  localparam logic [7:0] NCR_LIMIT = 8'(NCR_MAX);
  localparam logic [1:0] PRE_LAST  = 2'(PRE_FILL_BYTES - 1);

  seq_state_t  seq_q;
  byte_state_t bst_q;
  logic [5:0]  index_q;
  logic [31:0] arg_q;
  logic [2:0]  byte_index_q;
  logic [1:0]  pre_count_q;
  logic [7:0]  ncr_count_q;
  logic        cs_n_q, busy_q, done_q, timeout_q, start_q;
  logic [7:0]  r1_q, send_q;

  logic [6:0]  crc_value;
  logic [7:0]  frame_byte_d;
  logic [7:0]  issue_byte_d;
  logic [7:0]  ncr_next_d;
  logic        crc_clear_d;
  logic        crc_update_d;

  always_comb begin
    frame_byte_d = FILL_BYTE;
    case (byte_index_q)
      3'd0:    frame_byte_d = {CMD_START_BITS, index_q};
      3'd1:    frame_byte_d = arg_q[31:24];
      3'd2:    frame_byte_d = arg_q[23:16];
      3'd3:    frame_byte_d = arg_q[15:8];
      3'd4:    frame_byte_d = arg_q[7:0];
      3'd5:    frame_byte_d = {crc_value, 1'b1};
      default: frame_byte_d = FILL_BYTE;
    endcase
  end

  assign issue_byte_d = (seq_q == SEQ_CMD) ? frame_byte_d : FILL_BYTE;
  assign ncr_next_d   = (ncr_count_q == 8'hFF) ? ncr_count_q : ncr_count_q + 8'd1;
  assign crc_clear_d  = (seq_q == SEQ_IDLE) && command_start;
  assign crc_update_d = (seq_q == SEQ_CMD) && (bst_q == BYTE_ISSUE) && (byte_index_q < 3'd5);

  kfmmc_crc7 u_crc7 (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (crc_clear_d),
    .update_i (crc_update_d),
    .data_i   (frame_byte_d),
    .crc_o    (crc_value)
  );

  // Engine handshake: spi_start is a one-cycle request with spi_send_data already
  // valid; the engine acknowledges by raising spi_busy and completes by dropping it,
  // at which point spi_recv_data is valid. No new request until that completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq_q        <= SEQ_IDLE;
      bst_q        <= BYTE_ISSUE;
      index_q      <= 6'd0;
      arg_q        <= 32'd0;
      byte_index_q <= 3'd0;
      pre_count_q  <= 2'd0;
      ncr_count_q  <= 8'd0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_q      <= 1'b0;
      r1_q         <= FILL_BYTE;
      send_q       <= FILL_BYTE;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (seq_q)
        SEQ_IDLE: begin
          if (command_start) begin
            index_q      <= command_index;
            arg_q        <= command_argument;
            byte_index_q <= 3'd0;
            pre_count_q  <= 2'd0;
            ncr_count_q  <= 8'd0;
            busy_q       <= 1'b1;
            cs_n_q       <= 1'b0;
            r1_q         <= FILL_BYTE;
            timeout_q    <= 1'b0;
            bst_q        <= BYTE_ISSUE;
            seq_q        <= (PRE_FILL_BYTES > 0) ? SEQ_PRE : SEQ_CMD;
          end
        end
        SEQ_PRE, SEQ_CMD, SEQ_RESP, SEQ_POST: begin
          case (bst_q)
            BYTE_ISSUE: begin
              start_q <= 1'b1;
              send_q  <= issue_byte_d;
              bst_q   <= BYTE_WAIT_HI;
            end
            BYTE_WAIT_HI: begin
              if (spi_busy) bst_q <= BYTE_WAIT_LO;
            end
            BYTE_WAIT_LO: begin
              if (!spi_busy) begin
                bst_q  <= BYTE_ISSUE;
                send_q <= FILL_BYTE;
                case (seq_q)
                  SEQ_PRE: begin
                    if (pre_count_q == PRE_LAST) seq_q <= SEQ_CMD;
                    else pre_count_q <= pre_count_q + 2'd1;
                  end
                  SEQ_CMD: begin
                    if (byte_index_q == 3'd5) seq_q <= SEQ_RESP;
                    else byte_index_q <= byte_index_q + 3'd1;
                  end
                  SEQ_RESP: begin
                    ncr_count_q <= ncr_next_d;
                    // A valid R1 on the last allowed byte still wins over the timeout.
                    if (!spi_recv_data[7]) begin
                      r1_q  <= spi_recv_data;
                      seq_q <= SEQ_POST;
                    end else if (ncr_next_d >= NCR_LIMIT) begin
                      r1_q      <= FILL_BYTE;
                      timeout_q <= 1'b1;
                      seq_q     <= SEQ_POST;
                    end
                  end
                  default: begin
                    cs_n_q <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    seq_q  <= SEQ_DONE;
                  end
                endcase
              end
            end
            default: bst_q <= BYTE_ISSUE;
          endcase
        end
        SEQ_DONE: seq_q <= SEQ_IDLE;
        default:  seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign command_busy     = busy_q;
  assign command_done     = done_q;
  assign response_r1      = r1_q;
  assign response_timeout = timeout_q;
  assign mmc_cs_n         = cs_n_q;
  assign spi_send_data    = send_q;
  assign spi_start        = start_q;
  assign debug_state      = seq_q;
  assign debug_byte_state = bst_q;

endmodule

// File: tb/tb_kfmmc_command_sequencer.sv
// Bench for the KFMMC command sequencer: SPI engine + card model, frame/response scoreboard.
module tb_kfmmc_command_sequencer;
  import kfmmc_pkg::*;

  localparam int NCR = 8;
  localparam int PRE = 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        command_start = 1'b0;
  logic [5:0]  command_index = 6'd0;
  logic [31:0] command_argument = 32'd0;
  logic        command_busy, command_done, response_timeout, mmc_cs_n, spi_start;
  logic [7:0]  response_r1, spi_send_data;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_recv_data = 8'hFF;
  seq_state_t  debug_state;
  byte_state_t debug_byte_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mosi_q[$];
  logic [7:0] exp_q[$];
  int         card_resp_at = 0;
  logic [7:0] card_resp_val = 8'hFF;
  bit         engine_active = 1'b0;
  bit         abort_xfer = 1'b0;

  kfmmc_command_sequencer #(.NCR_MAX(NCR), .PRE_FILL_BYTES(PRE)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .command_start    (command_start),
    .command_index    (command_index),
    .command_argument (command_argument),
    .command_busy     (command_busy),
    .command_done     (command_done),
    .response_r1      (response_r1),
    .response_timeout (response_timeout),
    .mmc_cs_n         (mmc_cs_n),
    .spi_send_data    (spi_send_data),
    .spi_start        (spi_start),
    .spi_busy         (spi_busy),
    .spi_recv_data    (spi_recv_data),
    .debug_state      (debug_state),
    .debug_byte_state (debug_byte_state)
  );

  // clock / reset
  initial forever #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC7 by polynomial long division of the 40-bit message.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // SPI engine + card: busy rises 1-3 posedges after start, lasts 2-5 cycles.
  logic [7:0] eng_byte;
  int         eng_pos, eng_delay, eng_len, eng_resp_n;
  bit         eng_restart;
  always begin
    @(posedge clock);
    if (reset_n && spi_start) begin
      eng_byte      = spi_send_data;
      eng_pos       = mosi_q.size();
      mosi_q.push_back(eng_byte);
      engine_active = 1'b1;
      eng_restart   = 1'b0;
      eng_delay     = $urandom_range(1, 3);
      eng_len       = $urandom_range(2, 5);
      for (int c = 0; c < eng_delay + eng_len; c++) begin
        @(negedge clock);
        if (spi_start) eng_restart = 1'b1;
        if (c == eng_delay - 1) spi_busy = 1'b1;
        if (c == eng_delay + eng_len - 1) begin
          eng_resp_n    = eng_pos - (PRE + 6) + 1;
          spi_recv_data = (eng_resp_n >= 1 && eng_resp_n == card_resp_at) ? card_resp_val : 8'hFF;
          if (!abort_xfer) begin
            check("send_stable", spi_send_data, eng_byte);
            check("start_once", eng_restart, 1'b0);
          end
          spi_busy = 1'b0;
        end
      end
      engine_active = 1'b0;
    end
  end

  // driver: one full command with scoreboard of MOSI bytes and result
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int resp_at,
                         input logic [7:0] resp_val, input bit poke_mid);
    logic [39:0] msg;
    int          n_resp, done_count, cyc;
    bit          got_done, exp_to;
    logic [7:0]  exp_r1;
    mosi_q.delete();
    exp_q.delete();
    card_resp_at  = resp_at;
    card_resp_val = resp_val;
    exp_to = !(resp_at >= 1 && resp_at <= NCR);
    exp_r1 = exp_to ? 8'hFF : resp_val;
    n_resp = exp_to ? NCR : resp_at;
    msg = {2'b01, idx, arg};
    repeat (PRE) exp_q.push_back(8'hFF);
    for (int i = 4; i >= 0; i--) exp_q.push_back(msg[i*8 +: 8]);
    exp_q.push_back({ref_crc7(msg), 1'b1});
    repeat (n_resp) exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);

    @(negedge clock);
    command_index    = idx;
    command_argument = arg;
    command_start    = 1'b1;
    @(negedge clock);
    command_start    = 1'b0;
    command_index    = 6'($urandom);
    command_argument = $urandom;
    check("accept_busy", command_busy, 1'b1);
    check("accept_cs_n", mmc_cs_n, 1'b0);

    got_done = 1'b0;
    for (cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      command_start = poke_mid && (cyc == 20);
      @(negedge clock);
      if (command_done) got_done = 1'b1;
    end
    command_start = 1'b0;
    check("done_seen", got_done, 1'b1);
    check("done_r1", response_r1, exp_r1);
    check("done_timeout", response_timeout, exp_to);
    check("done_cs_n", mmc_cs_n, 1'b1);
    check("done_busy", command_busy, 1'b0);

    done_count = 0;
    repeat (40) begin
      @(negedge clock);
      if (command_done) done_count++;
    end
    check("extra_done", done_count, 0);
    check("idle_busy", command_busy, 1'b0);
    check("r1_hold", response_r1, exp_r1);
    check("idle_send", spi_send_data, 8'hFF);
    check("mosi_len", mosi_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mosi_q.size(); i++)
      check("mosi_byte", mosi_q[i], exp_q[i]);
  endtask

  initial begin
    int i_wait;
    #12;
    check("rst_cs_n", mmc_cs_n, 1'b1);
    check("rst_busy", command_busy, 1'b0);
    check("rst_done", command_done, 1'b0);
    check("rst_start", spi_start, 1'b0);
    check("rst_r1", response_r1, 8'hFF);
    check("rst_timeout", response_timeout, 1'b0);
    check("rst_send", spi_send_data, 8'hFF);
    check("rst_state", debug_state, SEQ_IDLE);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_cmd(6'd0, 32'h0, 2, 8'h01, 1'b0);
    run_cmd(6'd8, 32'h0000_01AA, 1, 8'h05, 1'b0);
    run_cmd(6'd17, 32'h1234_5678, 0, 8'h00, 1'b0);
    run_cmd(6'd55, 32'hDEAD_BEEF, NCR, 8'h00, 1'b0);
    run_cmd(6'd24, 32'hA5A5_0F0F, 3, 8'h04, 1'b1);

    // asynchronous reset in the middle of CMD byte 3
    mosi_q.delete();
    card_resp_at = 0;
    @(negedge clock);
    command_index    = 6'd9;
    command_argument = 32'hCAFE_F00D;
    command_start    = 1'b1;
    @(negedge clock);
    command_start = 1'b0;
    i_wait = 0;
    while (mosi_q.size() < PRE + 4 && i_wait < 3000) begin
      @(negedge clock);
      i_wait++;
    end
    check("reach_byte3", mosi_q.size() >= PRE + 4, 1'b1);
    @(posedge clock);
    #2;
    abort_xfer = 1'b1;
    reset_n    = 1'b0;
    #1;
    check("arst_cs_n", mmc_cs_n, 1'b1);
    check("arst_busy", command_busy, 1'b0);
    check("arst_start", spi_start, 1'b0);
    check("arst_state", debug_state, SEQ_IDLE);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    i_wait = 0;
    while (engine_active && i_wait < 100) begin
      @(negedge clock);
      i_wait++;
    end
    check("engine_idle", engine_active, 1'b0);
    abort_xfer = 1'b0;
    run_cmd(6'd1, 32'h4000_0000, 1, 8'h00, 1'b0);

    for (int n = 0; n < 16; n++)
      run_cmd(6'($urandom_range(0, 63)), $urandom, $urandom_range(0, NCR),
              8'($urandom_range(0, 127)), n[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
